// File: rtl/fifo_pkg.sv
// Shared FIFO definitions plus the state encoding of the serial transmitter
// that drains the byte FIFO.
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;

  // One FIFO entry: the enable flag marks bytes that should go out on the wire.
  typedef struct packed {
    logic                   en;
    logic [FIFO_DATA_W-1:0] data;
  } t_fifo_data;

  // Transmitter sequence: fetch an entry, then frame it as start/data/stop.
  typedef enum logic [2:0] {
    IDLE,
    POP,
    WAIT,
    START,
    DATA,
    STOP
  } t_utx_state;

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Held at zero while cleared so each serial state starts on a full bit period.
module fifo_uart_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_tick
);

  localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free-running modulo-CLKS_PER_BIT counter, restarted from zero while cleared.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == TERM) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = (r_cnt == TERM) && !i_clr;

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining serial transmitter. Pops one entry at a time, discards entries
// whose enable flag is clear, and sends the rest as start/8 data/stop frames,
// LSB first, on a registered idle-high line.
module fifo_uart_tx
  import fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_RD_LAT  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        empty,
  input  t_fifo_data  data_out,
  output logic        pop,
  output logic        tx,
  output logic        busy,
  output logic [15:0] sent_cnt,
  output logic [7:0]  drop_cnt
);

  // Last index of the read-latency wait and of the stop-bit sequence.
  localparam logic WAIT_LAST = 1'(FIFO_RD_LAT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  t_utx_state             r_state;
  logic                   r_pop;
  logic                   r_tx;
  logic                   r_busy;
  logic [FIFO_DATA_W-1:0] r_shift;
  logic [2:0]             r_bit_idx;
  logic                   r_stop_idx;
  logic                   r_wait_idx;
  logic [15:0]            r_sent_cnt;
  logic [7:0]             r_drop_cnt;

  logic                   w_tick;
  logic                   w_tmr_clr;

  // Saturating increment for the discard statistic.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The timer only runs while a frame is on the wire; it is parked at zero
  // otherwise so the start bit gets a full period.
  assign w_tmr_clr = !((r_state == START) || (r_state == DATA) || (r_state == STOP));

  fifo_uart_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_tmr_clr),
    .o_tick (w_tick)
  );

  // Transmit sequencer: fetch, qualify, and serialise one entry at a time.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pop      <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_wait_idx <= 1'b0;
      r_sent_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_pop <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (enable && !empty) begin
            r_state <= POP;
            r_pop   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        POP: begin
          r_state    <= WAIT;
          r_wait_idx <= 1'b0;
        end
        WAIT: begin
          // Read data is valid only on the final latency cycle.
          if (r_wait_idx == WAIT_LAST) begin
            r_shift <= data_out.data;
            if (data_out.en) begin
              r_state <= START;
              r_tx    <= 1'b0;
            end else begin
              r_state    <= IDLE;
              r_busy     <= 1'b0;
              r_drop_cnt <= sat_inc8(r_drop_cnt);
            end
          end else begin
            r_wait_idx <= r_wait_idx + 1'b1;
          end
        end
        START: begin
          if (w_tick) begin
            r_state   <= DATA;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[FIFO_DATA_W-1:1]};
            r_bit_idx <= '0;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_idx == 3'd7) begin
              r_state    <= STOP;
              r_tx       <= 1'b1;
              r_stop_idx <= 1'b0;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[FIFO_DATA_W-1:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_stop_idx == STOP_LAST) begin
              r_state    <= IDLE;
              r_busy     <= 1'b0;
              r_sent_cnt <= r_sent_cnt + 16'd1;
            end else begin
              r_stop_idx <= r_stop_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign pop      = r_pop;
  assign tx       = r_tx;
  assign busy     = r_busy;
  assign sent_cnt = r_sent_cnt;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: two instances (4 clk/bit, 1 stop, read
// latency 1; and 2 clk/bit, 2 stop, read latency 2), each fed by a queue-based
// FIFO model, with frame traces compared against a bit-level frame model.
module tb_fifo_uart_tx;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable1, enable2;
  logic        empty1, empty2;
  t_fifo_data  data1 = '0, data2 = '0, stg2 = '0;
  logic        pop1, pop2, tx1, tx2, busy1, busy2;
  logic [15:0] sent1, sent2;
  logic [7:0]  drop1, drop2;

  t_fifo_data q1[$];
  t_fifo_data q2[$];

  int n_pass  = 0;
  int n_total = 0;
  int pops1   = 0;
  int pop_viol = 0;
  logic pop1_prev = 1'b0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .FIFO_RD_LAT(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable1), .empty(empty1), .data_out(data1),
    .pop(pop1), .tx(tx1), .busy(busy1), .sent_cnt(sent1), .drop_cnt(drop1));

  fifo_uart_tx #(.CLKS_PER_BIT(2), .FIFO_RD_LAT(2), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .empty(empty2), .data_out(data2),
    .pop(pop2), .tx(tx2), .busy(busy2), .sent_cnt(sent2), .drop_cnt(drop2));

  assign empty1 = (q1.size() == 0);
  assign empty2 = (q2.size() == 0);

  // FIFO model, read latency 1.
  always @(posedge clk) begin
    if (pop1 && q1.size() > 0) data1 <= q1.pop_front();
  end

  // FIFO model, read latency 2.
  always @(posedge clk) begin
    if (pop2 && q2.size() > 0) stg2 <= q2.pop_front();
    data2 <= stg2;
  end

  // Pop monitor: counts pops, flags pops while empty or on consecutive cycles.
  always @(negedge clk) begin
    if (pop1) begin
      pops1 <= pops1 + 1;
      if (empty1) pop_viol <= pop_viol + 1;
    end
    if (pop1 && pop1_prev) pop_viol <= pop_viol + 1;
    pop1_prev <= pop1;
  end

  typedef struct {
    logic        en;
    logic [7:0]  data;
    logic [15:0] exp_sent;
    logic [7:0]  exp_drop;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push1(input logic en, input logic [7:0] d);
    t_fifo_data e;
    e.en = en; e.data = d;
    q1.push_back(e);
  endtask

  task automatic push2(input logic en, input logic [7:0] d);
    t_fifo_data e;
    e.en = en; e.data = d;
    q2.push_back(e);
  endtask

  // Expected line level for frame bit k: start, 8 data LSB first, then stop/idle.
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    return 1'b1;
  endfunction

  function automatic logic cur_tx(input int which);
    return (which == 1) ? tx1 : tx2;
  endfunction

  function automatic logic cur_busy(input int which);
    return (which == 1) ? busy1 : busy2;
  endfunction

  // Wait (bounded) for the start bit, then record ncyc cycles of tx and busy.
  task automatic capture(input int which, input int ncyc, input logic [7:0] d,
                         input string name, output int waited);
    logic [63:0] act_tx, exp_tx, act_bsy, exp_bsy;
    int cpb, flen;
    cpb  = (which == 1) ? 4 : 2;
    flen = (which == 1) ? 40 : 22;
    waited = 0;
    while (cur_tx(which) !== 1'b0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) begin
      n_total++;
      $display("FAIL %s: no start bit within %0d cycles", name, waited);
      return;
    end
    act_tx = '0; exp_tx = '0; act_bsy = '0; exp_bsy = '0;
    for (int c = 0; c < ncyc; c++) begin
      act_tx[c]  = cur_tx(which);
      exp_tx[c]  = frame_bit(d, c / cpb);
      act_bsy[c] = cur_busy(which);
      exp_bsy[c] = (c < flen);
      @(negedge clk);
    end
    chk({name, "_tx"}, act_tx, exp_tx);
    chk({name, "_busy"}, act_bsy, exp_bsy);
  endtask

  task automatic wait_idle(input int which, input string name);
    int n;
    n = 0;
    while (cur_busy(which) !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_total++;
      $display("FAIL %s: busy never dropped", name);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int w, lows, snap;
    vecs[0] = '{1'b0, 8'hAA, 16'd5, 8'd1};
    vecs[1] = '{1'b1, 8'h55, 16'd6, 8'd1};
    vecs[2] = '{1'b0, 8'h13, 16'd6, 8'd2};
    vecs[3] = '{1'b1, 8'h00, 16'd7, 8'd2};
    vecs[4] = '{1'b1, 8'hFF, 16'd8, 8'd2};
    vecs[5] = '{1'b1, 8'hA5, 16'd9, 8'd2};

    reset = 1'b1; enable1 = 1'b0; enable2 = 1'b0;
    idle_cycles(3);
    chk("rst_tx",   64'(tx1),   64'd1);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_pop",  64'(pop1),  64'd0);
    chk("rst_sent", 64'(sent1), 64'd0);
    chk("rst_drop", 64'(drop1), 64'd0);
    reset = 1'b0; enable1 = 1'b1; enable2 = 1'b1;
    idle_cycles(2);

    // Single frame 8'h2F: pop timing and start-bit latency.
    push1(1'b1, 8'h2F);
    @(negedge clk);
    chk("t1_pop_hi", 64'(pop1), 64'd1);
    @(negedge clk);
    chk("t1_pop_lo", 64'(pop1), 64'd0);
    chk("t1_tx_pre", 64'(tx1), 64'd1);
    capture(1, 41, 8'h2F, "t1_frame", w);
    chk("t1_latency", 64'(w), 64'd1);
    wait_idle(1, "t1_idle");
    chk("t1_sent", 64'(sent1), 64'd1);
    chk("t1_pops", 64'(pops1), 64'd1);

    // Four queued bytes go out in order with idle gaps.
    push1(1'b1, 8'd47); push1(1'b1, 8'd48); push1(1'b1, 8'd49); push1(1'b1, 8'd50);
    capture(1, 41, 8'd47, "t2_f0", w);
    capture(1, 41, 8'd48, "t2_f1", w);
    chk("t2_gap1", 64'(w >= 1), 64'd1);
    capture(1, 41, 8'd49, "t2_f2", w);
    capture(1, 41, 8'd50, "t2_f3", w);
    wait_idle(1, "t2_idle");
    chk("t2_sent",  64'(sent1),  64'd5);
    chk("t2_empty", 64'(empty1), 64'd1);
    chk("t2_pops",  64'(pops1),  64'd5);

    // Table of single entries: dropped or framed, with running statistics.
    for (int i = 0; i < 6; i++) begin
      push1(vecs[i].en, vecs[i].data);
      if (vecs[i].en) begin
        capture(1, 41, vecs[i].data, $sformatf("vec%0d", i), w);
      end else begin
        lows = 0;
        for (int c = 0; c < 12; c++) begin
          @(negedge clk);
          if (tx1 !== 1'b1) lows++;
        end
        chk($sformatf("vec%0d_nolow", i), 64'(lows), 64'd0);
      end
      wait_idle(1, $sformatf("vec%0d_idle", i));
      chk($sformatf("vec%0d_sent", i), 64'(sent1), 64'(vecs[i].exp_sent));
      chk($sformatf("vec%0d_drop", i), 64'(drop1), 64'(vecs[i].exp_drop));
    end

    // Discard counter saturates at 8'hFF.
    force dut1.r_drop_cnt = 8'hFE;
    @(negedge clk);
    release dut1.r_drop_cnt;
    @(negedge clk);
    push1(1'b0, 8'h01);
    idle_cycles(8);
    chk("sat_ff", 64'(drop1), 64'hFF);
    push1(1'b0, 8'h02);
    idle_cycles(8);
    chk("sat_hold", 64'(drop1), 64'hFF);

    // Reset in the middle of data bit 3 of 8'hF0.
    push1(1'b1, 8'hF0);
    capture(1, 18, 8'hF0, "t4_prefix", w);
    reset = 1'b1;
    @(negedge clk);
    chk("t4_tx",   64'(tx1),   64'd1);
    chk("t4_busy", 64'(busy1), 64'd0);
    chk("t4_sent", 64'(sent1), 64'd0);
    chk("t4_drop", 64'(drop1), 64'd0);
    reset = 1'b0;
    snap = pops1;
    lows = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (tx1 !== 1'b1) lows++;
    end
    chk("t4_nopop", 64'(pops1 - snap), 64'd0);
    chk("t4_txhi",  64'(lows), 64'd0);

    // enable low holds the queue; a one-cycle enable pulse releases one entry.
    enable1 = 1'b0;
    push1(1'b1, 8'h11); push1(1'b1, 8'h22); push1(1'b1, 8'h33);
    idle_cycles(20);
    chk("t5_nopop", 64'(pops1 - snap), 64'd0);
    chk("t5_busy",  64'(busy1), 64'd0);
    enable1 = 1'b1;
    @(negedge clk);
    enable1 = 1'b0;
    capture(1, 41, 8'h11, "t5_f0", w);
    idle_cycles(100);
    chk("t5_left", 64'(q1.size()), 64'd2);
    chk("t5_pops", 64'(pops1 - snap), 64'd1);
    chk("t5_sent", 64'(sent1), 64'd1);
    enable1 = 1'b1;
    capture(1, 41, 8'h22, "t5_f1", w);
    capture(1, 41, 8'h33, "t5_f2", w);
    wait_idle(1, "t5_idle");
    chk("t5_sent3", 64'(sent1), 64'd3);
    chk("pop_rules", 64'(pop_viol), 64'd0);

    // Two stop bits at two clocks per bit, read latency 2: 22-cycle frame.
    push2(1'b1, 8'hC3);
    capture(2, 26, 8'hC3, "t6_f0", w);
    wait_idle(2, "t6_idle");
    chk("t6_sent", 64'(sent2), 64'd1);
    push2(1'b0, 8'h77);
    idle_cycles(10);
    chk("t6_drop", 64'(drop2), 64'd1);
    force dut2.r_sent_cnt = 16'hFFFF;
    @(negedge clk);
    release dut2.r_sent_cnt;
    @(negedge clk);
    chk("t6_preload", 64'(sent2), 64'hFFFF);
    push2(1'b1, 8'h3C);
    capture(2, 26, 8'h3C, "t6_f1", w);
    wait_idle(2, "t6_idle2");
    chk("t6_wrap", 64'(sent2), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
